usb_uart_client: RTL and testbench
==================================

Name: usb_uart_client

Overview:
- Application-side master for the USB CDC bridge byte port (uart_we / uart_re / uart_di / uart_do / uart_wait).
- Converts an application TX valid/ready byte stream into bridge write requests, buffered in a TX FIFO.
- Issues bridge read requests and presents received bytes as an RX valid/ready stream.
- Sits between user logic (e.g. tone command parser) and the USB bridge, all in the 48 MHz domain.

Parameters:
- TX_DEPTH, 16: TX FIFO depth in bytes; power of 2, minimum 2.
- TX_AW, 4: log2(TX_DEPTH).
- READ_TIMEOUT, 256: maximum cycles a read request is held without completion before it is abandoned; minimum 2.

Ports:
- clk_48mhz  input  1  system clock.
- resetn  input  1  asynchronous active-low reset.
- tx_data  input  8  application byte to send to host.
- tx_valid  input  1  tx_data valid.
- tx_ready  output  1  FIFO not full; the byte transfers when tx_valid && tx_ready.
- rx_data  output  8  byte received from host.
- rx_valid  output  1  rx_data holds an unconsumed byte.
- rx_ready  input  1  application consumes rx_data when rx_valid && rx_ready.
- uart_we  output  1  bridge write request.
- uart_re  output  1  bridge read request.
- uart_di  output  8  write byte to bridge.
- uart_do  input  8  read byte from bridge.
- uart_wait  input  1  bridge stall; a request completes in a cycle where it is asserted and uart_wait=0.
- tx_level  output  TX_AW+1  current TX FIFO occupancy, 0..TX_DEPTH.
- busy  output  1  high when state != IDLE or tx_level != 0.

Behaviour:
- Reset (resetn=0, async):
  - state=IDLE; FIFO emptied; tx_level=0.
  - Outputs: tx_ready=1, rx_valid=0, rx_data=0, uart_we=0, uart_re=0, uart_di=0, busy=0.
  - Internal: last_grant=READ (so the first grant prefers WRITE); timeout counter=0.
  - Reset asserted mid-request drops uart_we/uart_re immediately; any in-flight byte is lost.
- TX FIFO:
  - Circular buffer with TX_AW-bit pointers and a TX_AW+1-bit count.
  - Push on tx_valid && tx_ready. Pop only on write completion.
  - Simultaneous push and pop leaves the count unchanged.
  - tx_ready = (count != TX_DEPTH), registered-equivalent (no combinational path from tx_valid).
  - Pointers wrap modulo TX_DEPTH.
- FSM states: IDLE, WRITE, READ.
  - IDLE:
    - write_req = FIFO non-empty. read_req = !rx_valid.
    - Both requests: grant the one opposite last_grant (round-robin).
    - One request: grant it.
    - Neither: stay in IDLE.
    - On entering WRITE or READ, update last_grant.
  - WRITE:
    - uart_we=1 and uart_di=FIFO head, held stable while uart_wait=1.
    - When uart_wait=0: pop FIFO, drop uart_we next cycle, return to IDLE.
  - READ:
    - uart_re=1; the timeout counter increments each cycle uart_wait=1.
    - When uart_wait=0: capture uart_do into rx_data, set rx_valid=1, clear counter, go to IDLE.
    - When the counter reaches READ_TIMEOUT-1 with uart_wait still 1: drop uart_re, clear counter, go to IDLE, no data captured.
    - The timeout prevents an idle host from starving writes.
- Requests are registered outputs.
  - A completed request is deasserted on the following cycle.
  - Back-to-back transfers have at least one IDLE cycle between them (≤1 request per 2 cycles).
- RX holding register:
  - rx_valid clears on rx_valid && rx_ready.
  - No read is issued while rx_valid=1, so the register cannot overflow.
  - Consume and capture never coincide, because READ entry requires rx_valid=0.
- uart_di holds its last value in IDLE. uart_re and uart_we are never both 1.

Optional Feature:
- Macro USB_UART_CLIENT_STATS_EN.
- Defined:
  - Adds outputs tx_count[15:0] and rx_count[15:0], incremented on each completed write and read respectively, wrapping at 16 bits.
  - Adds output rd_timeouts[7:0], incremented on each read timeout and saturating at 255.
  - All three reset to 0.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, uart_wait=0, push 0x41,0x42,0x43 with rx_ready=0:
  - uart_we pulses 3 times with uart_di=0x41,0x42,0x43, interleaved with one read.
  - rx_valid=1 holding uart_do from that read; tx_level returns to 0.
- Fill FIFO with 16 bytes while uart_wait=1:
  - tx_ready=0 at tx_level=16; a 17th push is refused.
  - After uart_wait drops, all 16 bytes go out in order.
- uart_wait=1 constantly, no TX data, READ_TIMEOUT=8:
  - uart_re is high for 8 cycles, then drops.
  - The next read is issued after one IDLE cycle; rx_valid stays 0.
- Host byte 0x5A with uart_wait=0 during READ, rx_ready=0:
  - rx_data=0x5A, rx_valid=1, no further uart_re.
  - Assert rx_ready for 1 cycle, then rx_valid=0 and a read resumes.
- FIFO non-empty and rx_valid=0 continuously, uart_wait=0:
  - Grants strictly alternate WRITE, READ, WRITE, READ; uart_we and uart_re are never both high.
- Assert resetn=0 while uart_we=1 with 5 bytes queued:
  - uart_we=0 asynchronously; tx_level=0 and rx_valid=0 after release.
  - With USB_UART_CLIENT_STATS_EN, all counters read 0.

Source files
------------

// File: rtl/usb_uart_client_if.sv
// Byte port between the application-side client and the USB CDC bridge.
// The client is the master; the bridge (or a bench model) is the slave.
interface usb_uart_client_if;
    logic       uart_we;
    logic       uart_re;
    logic [7:0] uart_di;
    logic [7:0] uart_do;
    logic       uart_wait;

    modport master (
        output uart_we,
        output uart_re,
        output uart_di,
        input  uart_do,
        input  uart_wait
    );

    modport slave (
        input  uart_we,
        input  uart_re,
        input  uart_di,
        output uart_do,
        output uart_wait
    );
endinterface

// File: rtl/usb_uart_client.sv
// Application-side master for the USB CDC bridge byte port: TX FIFO to bridge writes,
// bridge reads to an RX valid/ready stream. Optional counters via USB_UART_CLIENT_STATS_EN.
module usb_uart_client #(
    parameter int unsigned TX_DEPTH     = 16,
    parameter int unsigned TX_AW        = 4,
    parameter int unsigned READ_TIMEOUT = 256
) (
    input  logic             clk_48mhz,
    input  logic             resetn,
    input  logic [7:0]       tx_data,
    input  logic             tx_valid,
    output logic             tx_ready,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    input  logic             rx_ready,
    usb_uart_client_if.master bridge,
    output logic [TX_AW:0]   tx_level,
`ifdef USB_UART_CLIENT_STATS_EN
    output logic [15:0]      tx_count,
    output logic [15:0]      rx_count,
    output logic [7:0]       rd_timeouts,
`endif
    output logic             busy
);
    localparam int unsigned ToW = $clog2(READ_TIMEOUT);

    typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

    state_e             state_q, state_d;
    logic [7:0]         mem_q [TX_DEPTH];
    logic [TX_AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [TX_AW:0]     count_q, count_d;
    logic               we_q, we_d, re_q, re_d;
    logic [7:0]         di_q, di_d;
    logic [7:0]         rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               last_rd_q, last_rd_d;
    logic [ToW-1:0]     to_cnt_q, to_cnt_d;
    logic               push, pop, write_req, read_req;
    logic               wr_done, rd_done, rd_to;

    assign tx_ready = (count_q != (TX_AW+1)'(TX_DEPTH));
    assign push     = tx_valid && tx_ready;
    assign wr_ptr_d = wr_ptr_q + TX_AW'(push);
    assign rd_ptr_d = rd_ptr_q + TX_AW'(pop);
    assign count_d  = count_q + (TX_AW+1)'(push) - (TX_AW+1)'(pop);

    always_ff @(posedge clk_48mhz) begin
        if (push) mem_q[wr_ptr_q] <= tx_data;
    end

    always_comb begin
        state_d    = state_q;
        we_d       = we_q;
        re_d       = re_q;
        di_d       = di_q;
        last_rd_d  = last_rd_q;
        to_cnt_d   = to_cnt_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = rx_valid_q && !rx_ready;
        pop        = 1'b0;
        wr_done    = 1'b0;
        rd_done    = 1'b0;
        rd_to      = 1'b0;
        write_req  = (count_q != '0);
        read_req   = !rx_valid_q;
        unique case (state_q)
            StIdle: begin
                // Round-robin: on contention grant whatever was not granted last.
                if (write_req && (!read_req || last_rd_q)) begin
                    state_d   = StWrite;
                    we_d      = 1'b1;
                    di_d      = mem_q[rd_ptr_q];
                    last_rd_d = 1'b0;
                end else if (read_req) begin
                    state_d   = StRead;
                    re_d      = 1'b1;
                    last_rd_d = 1'b1;
                end
            end
            StWrite: begin
                if (!bridge.uart_wait) begin
                    pop     = 1'b1;
                    wr_done = 1'b1;
                    we_d    = 1'b0;
                    state_d = StIdle;
                end
            end
            StRead: begin
                if (!bridge.uart_wait) begin
                    rx_data_d  = bridge.uart_do;
                    rx_valid_d = 1'b1;
                    rd_done    = 1'b1;
                    to_cnt_d   = '0;
                    re_d       = 1'b0;
                    state_d    = StIdle;
                end else if (to_cnt_q == ToW'(READ_TIMEOUT - 1)) begin
                    // Abandon the read so a silent host cannot starve writes.
                    rd_to    = 1'b1;
                    to_cnt_d = '0;
                    re_d     = 1'b0;
                    state_d  = StIdle;
                end else begin
                    to_cnt_d = to_cnt_q + ToW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                we_d    = 1'b0;
                re_d    = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            we_q       <= 1'b0;
            re_q       <= 1'b0;
            di_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            last_rd_q  <= 1'b1;
            to_cnt_q   <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            we_q       <= we_d;
            re_q       <= re_d;
            di_q       <= di_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            last_rd_q  <= last_rd_d;
            to_cnt_q   <= to_cnt_d;
        end
    end

    assign bridge.uart_we = we_q;
    assign bridge.uart_re = re_q;
    assign bridge.uart_di = di_q;
    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign tx_level       = count_q;
    assign busy           = (state_q != StIdle) || (count_q != '0);

`ifdef USB_UART_CLIENT_STATS_EN
    logic [15:0] tx_count_q, rx_count_q;
    logic [7:0]  rd_to_q;

    always_ff @(posedge clk_48mhz or negedge resetn) begin
        if (!resetn) begin
            tx_count_q <= '0;
            rx_count_q <= '0;
            rd_to_q    <= '0;
        end else begin
            if (wr_done) tx_count_q <= tx_count_q + 16'd1;
            if (rd_done) rx_count_q <= rx_count_q + 16'd1;
            if (rd_to && (rd_to_q != 8'hFF)) rd_to_q <= rd_to_q + 8'd1;
        end
    end

    assign tx_count    = tx_count_q;
    assign rx_count    = rx_count_q;
    assign rd_timeouts = rd_to_q;
`endif
endmodule

// File: tb/tb_usb_uart_client.sv
// Directed bench for usb_uart_client (TX_DEPTH=16, READ_TIMEOUT=8) with a bridge stub.
module tb_usb_uart_client;
    logic       clk_48mhz = 1'b0;
    logic       resetn;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [4:0] tx_level;
    logic       busy;
`ifdef USB_UART_CLIENT_STATS_EN
    logic [15:0] tx_count, rx_count;
    logic [7:0]  rd_timeouts;
`endif

    int errors = 0;
    int checks = 0;

    logic [7:0] wr_log[$];
    logic [7:0] kind_log[$];
    int         rd_cnt  = 0;
    int         both_hi = 0;

    usb_uart_client_if bif ();

    usb_uart_client #(
        .TX_DEPTH    (16),
        .TX_AW       (4),
        .READ_TIMEOUT(8)
    ) dut (
        .clk_48mhz  (clk_48mhz),
        .resetn     (resetn),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .bridge     (bif),
        .tx_level   (tx_level),
`ifdef USB_UART_CLIENT_STATS_EN
        .tx_count   (tx_count),
        .rx_count   (rx_count),
        .rd_timeouts(rd_timeouts),
`endif
        .busy       (busy)
    );

    always #5 clk_48mhz = ~clk_48mhz;

    // Bridge-side monitor: logs completed transfers seen at each clock edge.
    always @(posedge clk_48mhz) begin
        if (bif.uart_we && bif.uart_re) both_hi++;
        if (resetn && bif.uart_we && !bif.uart_wait) begin
            wr_log.push_back(bif.uart_di);
            kind_log.push_back(8'h57);
        end
        if (resetn && bif.uart_re && !bif.uart_wait) begin
            rd_cnt++;
            kind_log.push_back(8'h52);
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_48mhz);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        step(1);
        tx_valid = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0; tx_data = '0; tx_valid = 1'b0; rx_ready = 1'b0;
        bif.uart_wait = 1'b0; bif.uart_do = 8'h77;
        #12;
        checks++; if (tx_ready !== 1'b1) begin errors++; $display("FAIL reset_tx_ready got %b want 1", tx_ready); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_rx_valid got %b want 0", rx_valid); end
        checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data got %h want 00", rx_data); end
        checks++; if (bif.uart_we !== 1'b0 || bif.uart_re !== 1'b0) begin errors++; $display("FAIL reset_req got we=%b re=%b want 0 0", bif.uart_we, bif.uart_re); end
        checks++; if (bif.uart_di !== 8'h00) begin errors++; $display("FAIL reset_di got %h want 00", bif.uart_di); end
        checks++; if (tx_level !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL reset_level_busy got %0d/%b want 0/0", tx_level, busy); end
        resetn = 1'b1;
    endtask

    task automatic test_basic_tx();
        wr_log.delete(); rd_cnt = 0;
        push(8'h41); push(8'h42); push(8'h43);
        step(20);
        checks++; if (wr_log.size() != 3) begin errors++; $display("FAIL basic_wr_count got %0d want 3", wr_log.size()); end
        else begin
            checks++; if (wr_log[0] !== 8'h41 || wr_log[1] !== 8'h42 || wr_log[2] !== 8'h43) begin
                errors++; $display("FAIL basic_wr_data got %h %h %h want 41 42 43", wr_log[0], wr_log[1], wr_log[2]); end
        end
        checks++; if (rd_cnt != 1) begin errors++; $display("FAIL basic_rd_count got %0d want 1", rd_cnt); end
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h77) begin errors++; $display("FAIL basic_rx got %b/%h want 1/77", rx_valid, rx_data); end
        checks++; if (tx_level !== 5'd0) begin errors++; $display("FAIL basic_level got %0d want 0", tx_level); end
`ifdef USB_UART_CLIENT_STATS_EN
        checks++; if (tx_count !== 16'd3 || rx_count !== 16'd1) begin errors++; $display("FAIL basic_stats got %0d/%0d want 3/1", tx_count, rx_count); end
`endif
    endtask

    task automatic test_fifo_full();
        bif.uart_wait = 1'b1;
        for (int i = 0; i < 16; i++) push(8'h10 + 8'(i));
        checks++; if (tx_level !== 5'd16 || tx_ready !== 1'b0) begin errors++; $display("FAIL full_level got %0d/%b want 16/0", tx_level, tx_ready); end
        checks++; if (bif.uart_we !== 1'b1 || bif.uart_di !== 8'h10) begin errors++; $display("FAIL full_held got we=%b di=%h want 1 10", bif.uart_we, bif.uart_di); end
        push(8'hEE);
        checks++; if (tx_level !== 5'd16) begin errors++; $display("FAIL full_refuse got %0d want 16", tx_level); end
        wr_log.delete();
        bif.uart_wait = 1'b0;
        step(40);
        checks++; if (wr_log.size() != 16) begin errors++; $display("FAIL full_drain_count got %0d want 16", wr_log.size()); end
        else begin
            int bad = 0;
            for (int i = 0; i < 16; i++) if (wr_log[i] !== 8'h10 + 8'(i)) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL full_drain_order got %0d bad bytes want 0", bad); end
        end
        checks++; if (tx_level !== 5'd0 || busy !== 1'b0) begin errors++; $display("FAIL full_idle got %0d/%b want 0/0", tx_level, busy); end
    endtask

    task automatic test_rx_consume();
        rd_cnt = 0;
        bif.uart_do = 8'h5A;
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rx_consumed got %b want 0", rx_valid); end
        step(10);
        checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h5A) begin errors++; $display("FAIL rx_capture got %b/%h want 1/5a", rx_valid, rx_data); end
        checks++; if (rd_cnt != 1 || bif.uart_re !== 1'b0) begin errors++; $display("FAIL rx_single_read got %0d/%b want 1/0", rd_cnt, bif.uart_re); end
    endtask

    task automatic test_read_timeout();
        int n = 0;
        int lo = 0;
        int w = 0;
        bif.uart_wait = 1'b1;
        rx_ready = 1'b1;
        step(1);
        rx_ready = 1'b0;
        while (!bif.uart_re && w < 10) begin w++; step(1); end
        checks++; if (bif.uart_re !== 1'b1) begin errors++; $display("FAIL to_start got re=%b want 1", bif.uart_re); end
        while (bif.uart_re && n < 20) begin n++; step(1); end
        checks++; if (n != 8) begin errors++; $display("FAIL to_high_cycles got %0d want 8", n); end
        while (!bif.uart_re && lo < 20) begin lo++; step(1); end
        checks++; if (lo != 1) begin errors++; $display("FAIL to_idle_gap got %0d want 1", lo); end
        checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL to_rx_valid got %b want 0", rx_valid); end
`ifdef USB_UART_CLIENT_STATS_EN
        checks++; if (rd_timeouts !== 8'd1) begin errors++; $display("FAIL to_stats got %0d want 1", rd_timeouts); end
`endif
    endtask

    task automatic test_alternate();
        int w = 0;
        int bad = 0;
        for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
        while (!bif.uart_we && w < 20) begin w++; step(1); end
        checks++; if (bif.uart_we !== 1'b1) begin errors++; $display("FAIL alt_write_grant got we=%b want 1", bif.uart_we); end
        kind_log.delete(); both_hi = 0;
        rx_ready = 1'b1;
        bif.uart_wait = 1'b0;
        step(12);
        rx_ready = 1'b0;
        checks++; if (kind_log.size() != 6) begin errors++; $display("FAIL alt_count got %0d want 6", kind_log.size()); end
        else begin
            for (int i = 0; i < 6; i++) if (kind_log[i] !== ((i % 2 == 0) ? 8'h57 : 8'h52)) bad++;
            checks++; if (bad != 0) begin errors++; $display("FAIL alt_order got %0d out of place want 0", bad); end
        end
        checks++; if (both_hi != 0) begin errors++; $display("FAIL alt_both_high got %0d want 0", both_hi); end
        checks++; if (tx_level !== 5'd3) begin errors++; $display("FAIL alt_level got %0d want 3", tx_level); end
    endtask

    task automatic test_reset_mid_write();
        int w = 0;
        resetn = 1'b0;
        step(1);
        bif.uart_wait = 1'b1;
        rx_ready = 1'b0;
        resetn = 1'b1;
        for (int i = 0; i < 5; i++) push(8'hA0 + 8'(i));
        while (!bif.uart_we && w < 20) begin w++; step(1); end
        checks++; if (bif.uart_we !== 1'b1 || tx_level !== 5'd5 || bif.uart_di !== 8'hA0) begin
            errors++; $display("FAIL rst_pre got we=%b lvl=%0d di=%h want 1 5 a0", bif.uart_we, tx_level, bif.uart_di); end
        #3 resetn = 1'b0;
        #1;
        checks++; if (bif.uart_we !== 1'b0 || bif.uart_re !== 1'b0) begin errors++; $display("FAIL rst_async got we=%b re=%b want 0 0", bif.uart_we, bif.uart_re); end
`ifdef USB_UART_CLIENT_STATS_EN
        checks++; if (tx_count !== 16'd0 || rx_count !== 16'd0 || rd_timeouts !== 8'd0) begin
            errors++; $display("FAIL rst_stats got %0d/%0d/%0d want 0/0/0", tx_count, rx_count, rd_timeouts); end
`endif
        #2 resetn = 1'b1;
        #1;
        checks++; if (tx_level !== 5'd0 || rx_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rst_release got lvl=%0d rxv=%b busy=%b want 0 0 0", tx_level, rx_valid, busy); end
        step(12);
        checks++; if (rx_valid !== 1'b0 || tx_level !== 5'd0) begin errors++; $display("FAIL rst_after got rxv=%b lvl=%0d want 0 0", rx_valid, tx_level); end
    endtask

    initial begin
        test_reset();
        test_basic_tx();
        test_fifo_full();
        test_rx_consume();
        test_read_timeout();
        test_alternate();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
